// File: rtl/pwm_axil_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_axil_pkg                                                             |
// | Register map, AXI response codes and FSM state types for pwm_axil_slave. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pwm_axil_pkg;

  // Register indices, taken from address bits [3:2]
  localparam logic [1:0] C_REG_CTRL    = 2'd0;
  localparam logic [1:0] C_REG_PERIOD  = 2'd1;
  localparam logic [1:0] C_REG_DUTY    = 2'd2;
  localparam logic [1:0] C_REG_SCRATCH = 2'd3;
  localparam int         C_NUM_REGS    = int'(C_REG_SCRATCH) + 1;

  localparam int C_CTRL_ENABLE_BIT = 0;

  localparam logic [1:0] C_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  function automatic logic [1:0] axi_resp(input logic ok);
    return ok ? C_RESP_OKAY : C_RESP_SLVERR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_core                                                                 |
// | Free-running PWM counter with period/duty shadows reloaded at each wrap. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pwm_core #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [CNT_WIDTH-1:0] duty,
  output logic                 pwm_out
);

  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

  logic                 r_en_d;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] r_act_period;
  logic [CNT_WIDTH-1:0] r_act_duty;
  logic                 r_pwm;

  logic                 w_kill;
  logic                 w_wrap;
  logic                 w_load;
  logic [CNT_WIDTH-1:0] w_count_nxt;
  logic [CNT_WIDTH-1:0] w_period_nxt;
  logic [CNT_WIDTH-1:0] w_duty_nxt;

  // A zero programmed period stops output at once instead of waiting for a wrap;
  // an idle shadow period keeps reloading so a later nonzero PERIOD starts cleanly.
  always_comb begin
    w_kill       = !enable || (period == '0);
    w_wrap       = (r_act_period != '0) && (r_count >= (r_act_period - C_ONE));
    w_load       = !r_en_d || (r_act_period == '0) || w_wrap;
    w_count_nxt  = r_count;
    w_period_nxt = r_act_period;
    w_duty_nxt   = r_act_duty;
    if (w_kill) begin
      w_count_nxt  = '0;
      w_period_nxt = '0;
      w_duty_nxt   = '0;
    end else if (w_load) begin
      w_count_nxt  = '0;
      w_period_nxt = period;
      w_duty_nxt   = duty;
    end else begin
      w_count_nxt  = r_count + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en_d       <= 1'b0;
      r_count      <= '0;
      r_act_period <= '0;
      r_act_duty   <= '0;
      r_pwm        <= 1'b0;
    end else begin
      r_en_d       <= enable;
      r_count      <= w_count_nxt;
      r_act_period <= w_period_nxt;
      r_act_duty   <= w_duty_nxt;
      r_pwm        <= (w_period_nxt != '0) && (w_count_nxt < w_duty_nxt);
    end
  end

  assign pwm_out = r_pwm;

endmodule
`default_nettype wire

// File: rtl/pwm_axil_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_axil_slave                                                           |
// | AXI4-Lite slave with four R/W registers driving a PWM generator.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pwm_axil_slave
  import pwm_axil_pkg::*;
#(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_areset,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  output logic                                pwm_out
);

  localparam int C_STRB_W = C_S00_AXI_DATA_WIDTH / 8;

  logic                            clk;
  logic                            rst;
  assign clk = s00_axi_aclk;
  assign rst = s00_axi_areset;

  wr_state_t                       r_wr_state;
  wr_state_t                       w_wr_state_nxt;
  rd_state_t                       r_rd_state;
  rd_state_t                       w_rd_state_nxt;
  logic                            w_wr_accept;
  logic                            w_rd_accept;
  logic [1:0]                      w_widx;
  logic [1:0]                      w_ridx;
  logic [C_S00_AXI_DATA_WIDTH-1:0] r_regs [C_NUM_REGS];
  logic [C_S00_AXI_DATA_WIDTH-1:0] r_rdata;
  logic                            w_unused;

  assign w_widx   = s00_axi_awaddr[3:2];
  assign w_ridx   = s00_axi_araddr[3:2];
  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot,
                      s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Write channel: address and data are only taken together
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_accept    = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (s00_axi_awvalid && s00_axi_wvalid && !rst) begin
          w_wr_accept    = 1'b1;
          w_wr_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (s00_axi_bready) begin
          w_wr_state_nxt = W_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
    end else begin
      r_wr_state <= w_wr_state_nxt;
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_accept    = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        if (s00_axi_arvalid && !rst) begin
          w_rd_accept    = 1'b1;
          w_rd_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        if (s00_axi_rready) begin
          w_rd_state_nxt = R_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
    end else begin
      r_rd_state <= w_rd_state_nxt;
    end
  end

  // Register file; a same-edge read sees the pre-write contents
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_accept) begin
      for (int b = 0; b < C_STRB_W; b++) begin
        if (s00_axi_wstrb[b]) begin
          r_regs[w_widx][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd_accept) begin
      r_rdata <= r_regs[w_ridx];
    end
  end

  assign s00_axi_awready = w_wr_accept;
  assign s00_axi_wready  = w_wr_accept;
  assign s00_axi_bvalid  = (r_wr_state == W_RESP);
  assign s00_axi_bresp   = axi_resp(1'b1);
  assign s00_axi_arready = w_rd_accept;
  assign s00_axi_rvalid  = (r_rd_state == R_DATA);
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = axi_resp(1'b1);

  pwm_core #(
    .CNT_WIDTH (C_S00_AXI_DATA_WIDTH)
  ) u_pwm_core (
    .clk     (clk),
    .reset   (rst),
    .enable  (r_regs[C_REG_CTRL][C_CTRL_ENABLE_BIT]),
    .period  (r_regs[C_REG_PERIOD]),
    .duty    (r_regs[C_REG_DUTY]),
    .pwm_out (pwm_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_pwm_axil_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pwm_axil_slave                                                        |
// | Self-checking bench: register table, random R/W vs model, PWM waveforms. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pwm_axil_slave;

  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic        pwm_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model [4];
  logic        hist [$];
  bit          mon_on = 1'b0;
  int          run_len [$];
  logic        run_lvl [$];

  always #5 clk = ~clk;

  always @(negedge clk) if (mon_on) hist.push_back(pwm_out);

  pwm_axil_slave dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (areset),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .pwm_out         (pwm_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 16) begin step(1); n++; end
    chk("wr_handshake", 32'(awready && wready), 32'd1);
    step(1);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int b = 0; b < 4; b++) if (s[b]) model[a[3:2]][8*b +: 8] = d[8*b +: 8];
    n = 0;
    while (!bvalid && n < 16) begin step(1); n++; end
    chk("bresp_okay", {29'd0, bvalid, bresp}, 32'h4);
    step(1);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 16) begin step(1); n++; end
    step(1);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 16) begin step(1); n++; end
    chk("rresp_okay", {29'd0, rvalid, rresp}, 32'h4);
    d = rdata;
    step(1);
    rready = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    step(2);
    areset = 1'b0;
    model_clear();
  endtask

  task automatic build_runs();
    run_len.delete(); run_lvl.delete();
    foreach (hist[i]) begin
      if (i == 0 || hist[i] !== hist[i-1]) begin
        run_lvl.push_back(hist[i]);
        run_len.push_back(1);
      end else begin
        run_len[run_len.size()-1]++;
      end
    end
  endtask

  task automatic window_ones(input int n, output int ones);
    hist.delete(); mon_on = 1'b1;
    step(n);
    mon_on = 1'b0;
    ones = 0;
    foreach (hist[i]) if (hist[i] === 1'b1) ones++;
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [31:0] rd;
    logic [3:0]  ra, wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          ones, n;
    logic        prev;

    vecs[0] = '{4'h0, 32'h0101FFFF, 4'hF, 32'h0101FFFF};
    vecs[1] = '{4'h4, 32'habcd0001, 4'hF, 32'habcd0001};
    vecs[2] = '{4'h8, 32'hdead0011, 4'hF, 32'hdead0011};
    vecs[3] = '{4'hC, 32'hbeef0011, 4'hF, 32'hbeef0011};
    vecs[4] = '{4'h0, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF};
    vecs[5] = '{4'h0, 32'h12345678, 4'b0010, 32'hFFFF56FF};
    vecs[6] = '{4'hD, 32'h00000000, 4'b1001, 32'h00EF0000};

    awaddr = '0; araddr = '0; awprot = 3'b101; arprot = 3'b010;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; wstrb = '0;
    do_reset();

    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_pwm",    32'(pwm_out), 32'd0);
    chk("rst_rdata",  rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd);
      chk("rst_reg", rd, 32'd0);
    end

    // Table: write then read back
    for (int i = 0; i < 7; i++) begin
      axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
      axi_read(vecs[i].addr, rd);
      chk("table_read", rd, vecs[i].exp);
    end

    // One-sided valid must not be accepted
    awaddr = 4'hC; wdata = 32'h0BAD0BAD; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin chk("aw_only_ready", 32'({awready, wready}), 32'd0); step(1); end
    awvalid = 1'b0; wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin chk("w_only_ready", 32'({awready, wready}), 32'd0); step(1); end
    wvalid = 1'b0;
    axi_read(4'hC, rd);
    chk("one_sided_noeffect", rd, model[3]);

    // bready held low 5 cycles with a second write queued
    awaddr = 4'hC; wdata = 32'h11111111; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    n = 0;
    while (!awready && n < 16) begin step(1); n++; end
    step(1);
    wdata = 32'h22222222;
    for (int i = 0; i < 5; i++) begin
      chk("bhold_bvalid", 32'(bvalid), 32'd1);
      chk("bhold_noaw",   32'(awready), 32'd0);
      step(1);
    end
    bready = 1'b1;
    chk("bhold_noaw_last", 32'(awready), 32'd0);
    step(1);
    chk("second_aw", 32'(awready && wready), 32'd1);
    step(1);
    awvalid = 0; wvalid = 0;
    chk("second_bvalid", 32'(bvalid), 32'd1);
    step(1);
    bready = 0;
    model[3] = 32'h22222222;
    axi_read(4'hC, rd);
    chk("second_write_data", rd, 32'h22222222);

    // Read and write of DUTY on the same edge returns the old value
    awaddr = 4'h8; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    araddr = 4'h8; arvalid = 1; rready = 0;
    step(1);
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("same_edge_old", rdata, model[2]);
    rready = 1; step(1); rready = 0; bready = 0;
    model[2] = 32'hCAFEF00D;
    axi_read(4'h8, rd);
    chk("same_edge_new", rd, 32'hCAFEF00D);

    // PWM 10/3
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h4, 32'd10, 4'hF);
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    step(15);
    hist.delete(); mon_on = 1'b1; step(45); mon_on = 1'b0;
    build_runs();
    chk("pwm_runs_count", 32'(run_len.size() >= 8), 32'd1);
    for (int i = 1; i < run_len.size() - 1; i++)
      chk(run_lvl[i] ? "pwm_high_len" : "pwm_low_len", 32'(run_len[i]), run_lvl[i] ? 32'd3 : 32'd7);

    // DUTY=5 written just after a falling edge takes effect after the wrap
    prev = pwm_out; n = 0;
    while (!(prev === 1'b1 && pwm_out === 1'b0) && n < 40) begin prev = pwm_out; step(1); n++; end
    chk("pwm_fall_seen", 32'(pwm_out), 32'd0);
    hist.delete(); mon_on = 1'b1;
    axi_write(4'h8, 32'd5, 4'hF);
    step(30);
    mon_on = 1'b0;
    build_runs();
    if (run_len.size() >= 4) begin
      chk("mid_low7",  {run_lvl[0], 31'(run_len[0])}, 32'd7);
      chk("mid_high5", {run_lvl[1], 31'(run_len[1])}, 32'h80000005);
      chk("mid_low5",  {run_lvl[2], 31'(run_len[2])}, 32'd5);
      chk("mid_high5b",{run_lvl[3], 31'(run_len[3])}, 32'h80000005);
    end else begin
      chk("mid_runs_count", 32'(run_len.size()), 32'd4);
    end

    // Boundaries
    axi_write(4'h8, 32'd0, 4'hF);
    step(25); window_ones(30, ones);
    chk("duty0_const0", 32'(ones), 32'd0);
    axi_write(4'h8, 32'd20, 4'hF);
    step(25); window_ones(30, ones);
    chk("duty20_const1", 32'(ones), 32'd30);
    axi_write(4'h4, 32'd0, 4'hF);
    chk("period0_now", 32'(pwm_out), 32'd0);
    window_ones(20, ones);
    chk("period0_const0", 32'(ones), 32'd0);
    axi_write(4'h4, 32'd10, 4'hF);
    step(25);
    chk("period10_high", 32'(pwm_out), 32'd1);
    axi_write(4'h0, 32'h0, 4'hF);
    chk("disable_now", 32'(pwm_out), 32'd0);
    window_ones(15, ones);
    chk("disable_const0", 32'(ones), 32'd0);

    // Random traffic against the register model
    for (int k = 0; k < 40; k++) begin
      wa = 4'($urandom_range(0, 15));
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      axi_write(wa, wd, ws);
      ra = 4'($urandom_range(0, 15));
      axi_read(ra, rd);
      chk("rand_read", rd, model[ra[3:2]]);
    end

    // Reset in W_RESP
    axi_write(4'hC, 32'h5A5A5A5A, 4'hF);
    awaddr = 4'h8; wdata = 32'h77777777; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    step(1);
    awvalid = 0; wvalid = 0;
    chk("wresp_pre", 32'(bvalid), 32'd1);
    areset = 1'b1; step(1); areset = 1'b0;
    model_clear();
    chk("wresp_abort", 32'(bvalid), 32'd0);
    step(1);
    chk("wresp_stay", 32'(bvalid), 32'd0);

    // Reset in R_DATA
    axi_write(4'hC, 32'h5A5A5A5A, 4'hF);
    araddr = 4'hC; arvalid = 1; rready = 0;
    step(1);
    arvalid = 0;
    chk("rdata_pre", {31'(rvalid), 1'b0} ^ rdata, 32'h5A5A5A5A ^ 32'h2);
    areset = 1'b1; step(1); areset = 1'b0;
    model_clear();
    chk("rdata_abort_valid", 32'(rvalid), 32'd0);
    chk("rdata_abort_data", rdata, 32'd0);
    chk("rst_pwm_after", 32'(pwm_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd);
      chk("post_rst_reg", rd, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/pwm_axil_slave.md
PWM_AXIL_SLAVE -- requirements
Module: pwm_axil_slave

Interface
REQ-001 SHALL have parameter C_S00_AXI_DATA_WIDTH, default 32: AXI4-Lite data width; only 32 is supported.
REQ-002 SHALL have parameter C_S00_AXI_ADDR_WIDTH, default 4: byte address width covering four 32-bit registers.
REQ-003 SHALL have ports, in this order:
- s00_axi_aclk  in  1  sole clock; all logic on its rising edge.
- s00_axi_areset  in  1  synchronous, active-high reset.
- s00_axi_awaddr  in  4  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in / out  1 each  AW handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte enables.
- s00_axi_wvalid / s00_axi_wready  in / out  1 each  W handshake.
- s00_axi_bresp  out  2  write response.
- s00_axi_bvalid / s00_axi_bready  out / in  1 each  B handshake.
- s00_axi_araddr  in  4  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in / out  1 each  AR handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  read response.
- s00_axi_rvalid / s00_axi_rready  out / in  1 each  R handshake.
- pwm_out  out  1  PWM waveform.

Function
REQ-004 Register map (index = addr[3:2]; addr[1:0] ignored). All four registers SHALL be read/write and SHALL read back exactly what was last written:
- 0x0 CTRL: bit0 enable, other bits are storage only.
- 0x4 PERIOD.
- 0x8 DUTY.
- 0xC SCRATCH.
REQ-005 Write FSM SHALL have states W_IDLE and W_RESP.
- In W_IDLE, when awvalid and wvalid are both high, awready and wready SHALL pulse high together for one cycle and the register write SHALL take effect on that edge.
- The FSM then enters W_RESP with bvalid=1 and bresp=OKAY (2'b00).
REQ-006 A write SHALL NOT be accepted while only one of awvalid or wvalid is high; awready and wready SHALL stay low.
REQ-007 In W_RESP, bvalid SHALL hold until the cycle bready=1, then return to W_IDLE. No new write SHALL be accepted while bvalid=1.
REQ-008 Each byte lane i SHALL be written only if wstrb[i]=1; other bytes SHALL be retained.
REQ-009 Read FSM SHALL have states R_IDLE and R_DATA.
- In R_IDLE with arvalid=1, arready SHALL pulse for one cycle and rdata SHALL be registered.
- rvalid=1 and rresp=OKAY on the following cycle.
REQ-010 rdata and rvalid SHALL hold stable until rready=1, then the FSM returns to R_IDLE. No new AR SHALL be accepted while rvalid=1.
REQ-011 Read and write channels SHALL operate independently. A read and a write to the same register accepted on the same edge SHALL return the old value.
REQ-012 The PWM counter (32 bit) SHALL run only when CTRL[0]=1 and active PERIOD is nonzero.
- It counts 0 to active_period-1, then wraps to 0.
- pwm_out (registered) SHALL equal (counter < active_duty).
REQ-013 Active PERIOD/DUTY shadows SHALL load from PERIOD/DUTY at every wrap to 0, and on the first cycle after enable goes 0->1. Mid-period writes SHALL NOT glitch the current period.
REQ-014 Boundary behaviour:
- DUTY=0 gives pwm_out constant 0.
- DUTY>=PERIOD gives constant 1.
- PERIOD=0 or enable=0 forces pwm_out=0 and counter=0 within one cycle.

Reset
REQ-015 On s00_axi_areset=1 at a clock edge, the following SHALL be 0: all registers, shadows, counter, pwm_out, awready, wready, bvalid, arready, rvalid, rdata, bresp, rresp. Both FSMs SHALL return to IDLE.
REQ-016 Reset asserted mid-transaction SHALL abort it without completing the response.

Structure
REQ-017 Register offsets, the OKAY/SLVERR constants, and the FSM state typedefs SHALL reside in package pwm_axil_pkg.
REQ-018 PWM generation SHALL be the sub-module pwm_core (ports: clk, reset, enable, period, duty, pwm_out). The AXI logic SHALL stay in pwm_axil_slave.

Verification
REQ-019 Required directed scenarios:
- Write 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to 0x0, 0x4, 0x8, 0xC and read each back -> identical data, all responses OKAY.
- Write 0x0 with wstrb=4'b0010, wdata=0x12345678 after 0xFFFFFFFF -> readback 0xFFFF56FF.
- Hold bready=0 for 5 cycles after a write -> bvalid held 5 cycles, no awready pulse for a second queued write.
- PERIOD=10, DUTY=3, CTRL=1 -> pwm_out high 3 cycles, low 7 cycles, repeating; writing DUTY=5 mid-period -> change appears only after the next wrap.
- DUTY=0, then DUTY=20 with PERIOD=10 -> constant 0, then constant 1. PERIOD=0 -> 0.
- Assert reset during W_RESP and during R_DATA -> bvalid=rvalid=0 next cycle, all registers read 0.
